timer_controller: RTL
=====================

# timer_controller

Sequencing controller for the microwave countdown timer. It captures a 4-digit BCD cook time (MM:SS) from the keypad and loads it into the cascaded countdown counter chain. It then gates the chain's count enable from the 1 Hz tick, handles start, stop, cancel and door-open, and signals completion. It sits between the keypad/door inputs and the counter chain, and it is the only block that drives the chain's control pins.

## Interface
- DONE_CYCLES, default 3, number of cycles `done` stays high in DONE state (must be ≥1)
- clock  input  1  system clock, all logic on rising edge
- clear  input  1  synchronous active-high reset
- key_valid  input  1  one-cycle strobe, `key_digit` valid
- key_digit  input  4  BCD digit pressed; values >9 ignored
- start  input  1  one-cycle start/resume strobe
- stop  input  1  one-cycle pause strobe
- cancel  input  1  one-cycle cancel strobe
- door_open  input  1  level, 1 = door open
- tick  input  1  one-cycle 1 Hz pulse
- timer_zero  input  1  AND of all chain `zero` flags
- load_value  output  16  entry register {min_tens, min_units, sec_tens, sec_units}, parallel-load data for the chain
- counter_loadn  output  1  active-low load to chain
- counter_clearn  output  1  active-low clear to chain
- counter_enable  output  1  count-down enable to chain's least-significant stage
- heating  output  1  magnetron on
- done  output  1  cook-complete indication
- state  output  3  current FSM state encoding

## Operation
- States: IDLE, ENTRY, LOAD, RUNNING, PAUSED, DONE, CLR.
- IDLE: entry register is 0.
  - Valid key shifts the digit into `sec_units` and moves to ENTRY.
  - `start` is ignored (see Configuration).
- ENTRY: each valid key shifts the entry register left one digit and inserts the new digit at `sec_units`; the oldest digit is dropped.
  - `start` with nonzero entry and door closed → LOAD.
  - `start` with zero entry stays in ENTRY.
  - `stop` zeroes the entry register, stays in ENTRY.
- LOAD: exactly one cycle, `counter_loadn`=0, `counter_enable`=0 → RUNNING.
- RUNNING: `heating`=1 and `counter_enable` = `tick` & !`timer_zero`, so the chain never wraps.
  - `timer_zero`=1 → DONE.
  - `stop` or `door_open` → PAUSED.
- PAUSED: `heating`=0, `counter_enable`=0, chain value held.
  - `start` with door closed → RUNNING.
  - `start` with door open is ignored.
- DONE: `done`=1 for DONE_CYCLES cycles, `heating`=0, then → IDLE with the entry register zeroed.
- CLR: one cycle, `counter_clearn`=0, `counter_enable`=0, entry register zeroed → IDLE.
- `cancel` in any state except IDLE and CLR → CLR.
- Priority on simultaneous inputs: `cancel` > `door_open`/`stop` > `timer_zero` > `start` > `key_valid`.
- `counter_loadn` and `counter_clearn` are asserted only while `counter_enable`=0. The chain ignores load and clear while enabled.
- Keys are ignored outside IDLE and ENTRY.

## Timing
- All state and registers update on the rising edge of `clock`. Outputs are decoded from state with no added latency.
- Reset (`clear`=1) values:
  - state=IDLE
  - `load_value`=0
  - `counter_loadn`=1
  - `counter_clearn`=0 (held low while `clear` is high)
  - `counter_enable`=0
  - `heating`=0
  - `done`=0
- The first cycle after `clear` deasserts has `counter_clearn`=1.
- `start` in ENTRY at cycle N: LOAD at N+1, RUNNING from N+2. The first decrement can occur on the first `tick` at or after N+2.
- `tick` coinciding with `timer_zero`=1 produces no enable pulse.
- `clear` mid-run overrides everything. The next state is IDLE and `heating` drops the following cycle.

## Configuration
- `TIMER_CTRL_QUICK_START_EN` defined: `start` in IDLE with door closed loads 16'h0030 into the entry register and goes directly to LOAD, giving a 30 s cook.
- Not defined: `start` in IDLE is ignored.

## Structure
- Shared package `timer_pkg`:
  - state enum and 3-bit encoding
  - BCD digit width (4)
  - quick-start constant 16'h0030
  - DONE_CYCLES default
- Sub-module `digit_entry_shifter`: the 16-bit BCD shift register with shift, zero and preset inputs and >9 rejection. The FSM, output decode and done counter stay in `timer_controller`.

## Test plan
- Keys 1,2,3,0 then `start`:
  - `load_value`=16'h1230
  - `counter_loadn` low exactly one cycle
  - then RUNNING with `counter_enable` pulsing only on `tick`
- Entry 16'h0002, run with the chain model: two ticks bring `timer_zero` high, then `done` high for 3 cycles, then IDLE with `load_value`=0.
- Door opens while RUNNING:
  - PAUSED next cycle, `heating`=0, no enables on ticks
  - `start` with the door still open is ignored
  - door closed then `start` → RUNNING, remaining time unchanged
- `cancel` while PAUSED: CLR with `counter_clearn` low one cycle, then IDLE. Simultaneous `cancel` and `start` → CLR.
- Key 0xA and key strobes in RUNNING are ignored. Five keys 1..5 yield 16'h2345.
- `start` in IDLE: 16'h0030 loaded with `TIMER_CTRL_QUICK_START_EN` defined; no state change without it. `clear` mid-run restores all reset values.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer controller: state encoding,
// BCD entry widths, quick-start preset and done-pulse length.
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam int ENTRY_W = 4 * DIGIT_W;
  localparam int DONE_CYCLES_DEFAULT = 3;
  localparam logic [ENTRY_W-1:0] QUICK_START_VALUE = 16'h0030;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUNNING = 3'd3,
    ST_PAUSED  = 3'd4,
    ST_DONE    = 3'd5,
    ST_CLR     = 3'd6
  } state_e;

  function automatic logic digit_is_bcd(input logic [DIGIT_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/digit_entry_shifter.sv
// Four-digit BCD keypad entry register {min_tens, min_units, sec_tens, sec_units}.
// Priority: zero > preset > shift; shifted digits above 9 are rejected.
module digit_entry_shifter
  import timer_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               shift,
  input  logic               zero,
  input  logic               preset,
  input  logic [DIGIT_W-1:0] digit,
  output logic [ENTRY_W-1:0] value
);

  logic [ENTRY_W-1:0] value_d;
  logic [ENTRY_W-1:0] value_q;

  // Next entry value: oldest digit falls off the top on each accepted key.
  always_comb begin
    value_d = value_q;
    if (zero) begin
      value_d = {ENTRY_W{1'b0}};
    end else if (preset) begin
      value_d = QUICK_START_VALUE;
    end else if (shift && digit_is_bcd(digit)) begin
      value_d = {value_q[ENTRY_W-DIGIT_W-1:0], digit};
    end else begin
      value_d = value_q;
    end
  end

  // Entry register.
  always_ff @(posedge clock) begin
    if (clear) begin
      value_q <= {ENTRY_W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/timer_controller.sv
// Microwave countdown sequencer: keypad entry, load, run/pause, done and cancel.
// Optional feature: define TIMER_CTRL_QUICK_START_EN for a 30 s start from IDLE.
module timer_controller
  import timer_pkg::*;
#(
  parameter int DONE_CYCLES = DONE_CYCLES_DEFAULT
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               cancel,
  input  logic               door_open,
  input  logic               tick,
  input  logic               timer_zero,
  output logic [ENTRY_W-1:0] load_value,
  output logic               counter_loadn,
  output logic               counter_clearn,
  output logic               counter_enable,
  output logic               heating,
  output logic               done,
  output logic [2:0]         state
);

  localparam int CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_CYCLES - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] done_cnt_d, done_cnt_q;
  logic             shift_s, zero_s, preset_s, key_ok_s;
  logic [ENTRY_W-1:0] entry_s;

  digit_entry_shifter u_entry (
    .clock  (clock),
    .clear  (clear),
    .shift  (shift_s),
    .zero   (zero_s),
    .preset (preset_s),
    .digit  (key_digit),
    .value  (entry_s)
  );

  assign key_ok_s = key_valid && digit_is_bcd(key_digit);

  // Next-state logic; cancel beats stop/door, which beat timer_zero, start, keys.
  always_comb begin
    state_d    = state_q;
    done_cnt_d = {CNT_W{1'b0}};
    shift_s    = 1'b0;
    zero_s     = 1'b0;
    preset_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef TIMER_CTRL_QUICK_START_EN
        if (start && !door_open) begin
          preset_s = 1'b1;
          state_d  = ST_LOAD;
        end else if (key_ok_s) begin
          shift_s = 1'b1;
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (key_ok_s) begin
          shift_s = 1'b1;
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_ENTRY: begin
        if (cancel) begin
          zero_s  = 1'b1;
          state_d = ST_CLR;
        end else if (stop) begin
          zero_s = 1'b1;
        end else if (start) begin
          if ((entry_s != {ENTRY_W{1'b0}}) && !door_open) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_ENTRY;
          end
        end else if (key_ok_s) begin
          shift_s = 1'b1;
        end else begin
          state_d = ST_ENTRY;
        end
      end
      ST_LOAD: begin
        if (cancel) begin
          zero_s  = 1'b1;
          state_d = ST_CLR;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (cancel) begin
          zero_s  = 1'b1;
          state_d = ST_CLR;
        end else if (stop || door_open) begin
          state_d = ST_PAUSED;
        end else if (timer_zero) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_PAUSED: begin
        if (cancel) begin
          zero_s  = 1'b1;
          state_d = ST_CLR;
        end else if (stop || door_open) begin
          state_d = ST_PAUSED;
        end else if (start) begin
          state_d = ST_RUNNING;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (cancel) begin
          zero_s  = 1'b1;
          state_d = ST_CLR;
        end else if (done_cnt_q == CNT_LAST) begin
          zero_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
        end
      end
      ST_CLR: begin
        zero_s  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        zero_s  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and done-length counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      done_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Chain control is zero-enable whenever load or clear is low, so the chain never ignores them.
  assign counter_enable = (state_q == ST_RUNNING) && tick && !timer_zero && !clear;
  assign counter_loadn  = (state_q != ST_LOAD);
  assign counter_clearn = !(clear || (state_q == ST_CLR));
  assign heating        = (state_q == ST_RUNNING);
  assign done           = (state_q == ST_DONE);
  assign state          = state_q;
  assign load_value     = entry_s;

endmodule
